rambam_refresh_sched: RTL and testbench
=======================================

// Module: rambam_refresh_sched
// PURPOSE
// - Owns a bank of NUM_ENT redundant-masked bytes (8+D bits each) and periodically re-randomises them.
// - Each refresh step computes entry ^ mul_P(r), with fresh r of D bits taken from the RNG.
// - Sits between the masked S-box datapath (read/write client, highest priority) and the RNG.
// - The refresh engine sweeps every entry: automatically every PERIOD cycles, or on a start pulse.
// PARAMETERS
// - D        `d     mask degree; entry width W = 8+D, random word width D
// - P        `P     9-bit reduction polynomial passed to mul_add_p
// - NUM_ENT  16     number of entries; AW = $clog2(NUM_ENT)
// - PERIOD   1024   cycles between automatic sweeps; 0 = auto refresh disabled
// PORTS
// - clk        in   1    single clock, all state on posedge
// - rst        in   1    synchronous, active-high reset
// - dp_re      in   1    datapath read request
// - dp_we      in   1    datapath write request (dp_we and dp_re set together: write wins, no read)
// - dp_addr    in   AW   datapath entry index
// - dp_wdata   in   W    datapath write data
// - dp_rdata   out  W    read data, valid 1 cycle after dp_re
// - dp_rvalid  out  1    qualifies dp_rdata
// - start      in   1    request a sweep now (ignored while a sweep is active)
// - rnd_valid  in   1    RNG word available
// - rnd_data   in   D    random r
// - rnd_ready  out  1    consume rnd_data this cycle
// - busy       out  1    sweep in progress
// - sweep_done out  1    1-cycle pulse when the last entry has been refreshed
// BEHAVIOUR
// - Reset: all entries 0, dp_rdata 0, dp_rvalid 0, rnd_ready 0, busy 0, sweep_done 0; FSM IDLE; ptr 0; period counter 0.
// - Period counter: increments every cycle while IDLE; reaching PERIOD-1 raises an auto request and the counter clears.
//   The counter holds at 0 while busy.
// - FSM IDLE: on start or auto request -> FETCH, ptr=0, busy=1.
// - FSM FETCH: rnd_ready=1 only if the datapath does not write entry ptr this cycle.
//   When rnd_valid & rnd_ready: write entry[ptr] <= entry[ptr] ^ mul_P(rnd_data); go to NEXT.
//   The write is the same-cycle combinational output of mul_add_p.
// - FSM NEXT: if ptr==NUM_ENT-1 -> IDLE, sweep_done=1, busy=0; else ptr++, -> FETCH.
// - Throughput: 2 cycles per entry with a continuously valid RNG; a sweep takes 2*NUM_ENT cycles.
// - Conflict: a datapath write to entry ptr during FETCH forces rnd_ready=0, so no random word is consumed.
//   The datapath value is stored and the refresh of that entry retries next cycle.
//   A datapath write to any other entry proceeds in parallel with the refresh.
// - Datapath read of the entry being refreshed in the same cycle returns the pre-refresh value. Both shares are valid encodings.
// - Datapath access never stalls; dp_rvalid = registered dp_re & ~dp_we.
// - rnd_valid low: FSM waits in FETCH indefinitely; busy stays 1.
// - start while busy: dropped. start coinciding with an auto request: one sweep only.
// - Synchronous reset mid-sweep: aborts immediately. Entries are cleared, so a partial refresh leaves no state.
// STRUCTURE
// - rambam_pkg: W/AW localparams as functions of D and NUM_ENT; typedef enum logic [1:0] {IDLE, FETCH, NEXT} refresh_state_t.
// - One sub-module: mul_add_p #(.d(D),.P(P)), fed in=entry[ptr], r=rnd_data; its output is the refresh write data.
// - Entry storage is a flop array (NUM_ENT x W), not RAM: it needs the same-cycle read-modify-write.
// TESTING
// - Reset, then start with rnd_valid=1 and rnd_data=0: busy high 32 cycles (NUM_ENT=16); all entries unchanged; sweep_done once.
// - Write entry 3 = 10'h2A5 (D=2).
//   Sweep with r = 2'b01 -> entry 3 reads back 10'h2A5 ^ {1'b0,P}; decoding mod P yields the original byte.
// - Hold rnd_valid=0 during a sweep for 50 cycles: ptr frozen, no entry changes, busy=1; it resumes when rnd_valid returns.
// - During FETCH of ptr=5, dp_we to entry 5 with 10'h0FF:
//   rnd_ready=0 that cycle; next cycle entry 5 = 10'h0FF ^ mul_P(r); no RNG word lost.
// - PERIOD=8, no start: the sweep auto-starts 8 cycles after reset release; a start pulse while busy gives no second sweep.
// - Assert rst at ptr=7: next cycle busy=0, all entries 0, rnd_ready=0; a following start sweeps from ptr 0.

Source files
------------

// File: rtl/rambam_pkg.sv
// Shared types and width helpers for the masked-byte refresh scheduler.
package rambam_pkg;

  // Irreducible polynomial used when no other reduction polynomial is supplied.
  localparam logic [8:0] DEFAULT_P = 9'h11B;

  // Sweep engine states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    NEXT  = 2'd2
  } refresh_state_t;

  // Redundant representation of a byte: 8 data bits plus d mask-degree bits.
  function automatic int entry_width(input int d);
    return 8 + d;
  endfunction

  // Entry index width, never narrower than one bit.
  function automatic int addr_width(input int num_ent);
    return (num_ent > 1) ? $clog2(num_ent) : 1;
  endfunction

  // Width of a counter that has to hold 0 .. period-1.
  function automatic int count_width(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/rambam_refresh_sched_mul.sv
// mul_add_p: out = in ^ (r * P) over GF(2)[x], with no reduction.
// Adding a multiple of P leaves the value unchanged modulo P, so the
// result is another valid encoding of the same byte.
module mul_add_p #(
  parameter int         d = 2,
  parameter logic [8:0] P = 9'h11B
) (
  input  logic [8+d-1:0] in_val,
  input  logic [d-1:0]   r,
  output logic [8+d-1:0] out_val
);

  localparam int W = 8 + d;

  logic [W-1:0] prod;

  // Carry-less product r * P, then fold it into the incoming share.
  always_comb begin
    // NOTE: every always_comb output gets a value before any conditional
    // logic, so no path can leave it unassigned and infer a latch.
    prod = '0;
    for (int i = 0; i < d; i++) begin
      if (r[i]) begin
        prod = prod ^ (W'(P) << i);
      end
    end
    out_val = in_val ^ prod;
  end

endmodule

// File: rtl/rambam_refresh_sched.sv
// rambam_refresh_sched: bank of redundant-masked bytes that is periodically
// re-randomised.  The datapath port has absolute priority and never stalls;
// the sweep engine consumes one RNG word per entry and yields on conflicts.
module rambam_refresh_sched
  import rambam_pkg::*;
#(
  parameter int          D       = 2,
  parameter logic [8:0]  P       = DEFAULT_P,
  parameter int          NUM_ENT = 16,
  parameter int          PERIOD  = 1024,
  localparam int         W       = entry_width(D),
  localparam int         AW      = addr_width(NUM_ENT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dp_re,
  input  logic          dp_we,
  input  logic [AW-1:0] dp_addr,
  input  logic [W-1:0]  dp_wdata,
  output logic [W-1:0]  dp_rdata,
  output logic          dp_rvalid,
  input  logic          start,
  input  logic          rnd_valid,
  input  logic [D-1:0]  rnd_data,
  output logic          rnd_ready,
  output logic          busy,
  output logic          sweep_done
);

  localparam int            CW      = count_width(PERIOD);
  localparam logic          AUTO_EN = (PERIOD > 0);
  localparam logic [CW-1:0] PER_M1  = CW'((PERIOD > 0) ? PERIOD - 1 : 0);
  localparam logic [AW-1:0] LAST    = AW'(NUM_ENT - 1);

  refresh_state_t state_q;
  logic [AW-1:0]  ptr_q;
  logic           busy_q;
  logic           sweep_done_q;

  logic [CW-1:0]  per_cnt_q, per_cnt_d;
  logic [W-1:0]   entry_q [NUM_ENT];
  logic [W-1:0]   entry_d [NUM_ENT];
  logic [W-1:0]   rdata_q, rdata_d;
  logic           rvalid_q, rvalid_d;

  logic [W-1:0]   cur_entry;
  logic [W-1:0]   refresh_val;
  logic           dp_hit_ptr;
  logic           rnd_ready_c;
  logic           fire;
  logic           auto_req;
  logic           sweep_req;
  logic           last_ent;

  assign cur_entry = entry_q[ptr_q];

  mul_add_p #(
    .d (D),
    .P (P)
  ) u_mul (
    .in_val  (cur_entry),
    .r       (rnd_data),
    .out_val (refresh_val)
  );

  // Handshake and sweep-request decode.
  always_comb begin
    dp_hit_ptr  = dp_we && (dp_addr == ptr_q);
    rnd_ready_c = (state_q == FETCH) && !dp_hit_ptr;
    fire        = rnd_ready_c && rnd_valid;
    auto_req    = AUTO_EN && (state_q == IDLE) && (per_cnt_q == PER_M1);
    sweep_req   = (state_q == IDLE) && (start || auto_req);
    last_ent    = (ptr_q == LAST);
  end

  // Period counter: runs only while idle, clears when a sweep is launched.
  always_comb begin
    per_cnt_d = per_cnt_q;
    if ((state_q != IDLE) || sweep_req) begin
      per_cnt_d = '0;
    end else if (AUTO_EN) begin
      per_cnt_d = per_cnt_q + CW'(1);
    end
  end

  // Entry next-state: refresh write and datapath write never target the
  // same entry, because a datapath hit on ptr suppresses the refresh.
  always_comb begin
    for (int i = 0; i < NUM_ENT; i++) begin
      entry_d[i] = entry_q[i];
      if (fire && (ptr_q == AW'(i))) begin
        entry_d[i] = refresh_val;
      end
      if (dp_we && (dp_addr == AW'(i))) begin
        entry_d[i] = dp_wdata;
      end
    end
  end

  // Datapath read port: sees the pre-refresh value of the current cycle.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = dp_re && !dp_we;
    if (rvalid_d) begin
      rdata_d = (int'(dp_addr) < NUM_ENT) ? entry_q[dp_addr] : '0;
    end
  end

  // Storage, read register and period counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the entries live in flops rather than RAM and are cleared on
      // reset on purpose: an aborted sweep must not leave partial shares.
      for (int i = 0; i < NUM_ENT; i++) begin
        entry_q[i] <= '0;
      end
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      per_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples values from before this edge regardless of block order.
      entry_q   <= entry_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      per_cnt_q <= per_cnt_d;
    end
  end

  // Sweep FSM with registered busy / sweep_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      sweep_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sweep_req) begin
            state_q <= FETCH;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          if (fire) begin
            state_q <= NEXT;
          end
        end
        NEXT: begin
          if (last_ent) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b1;
          end else begin
            ptr_q   <= ptr_q + AW'(1);
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dp_rdata   = rdata_q;
  assign dp_rvalid  = rvalid_q;
  assign rnd_ready  = rnd_ready_c;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_rambam_refresh_sched.sv
// Self-checking bench for rambam_refresh_sched.  Instance u_dut (no auto
// refresh) is compared cycle by cycle against a sweep-level reference model;
// instance u_auto (PERIOD=8) checks the automatic sweep schedule.
module tb_rambam_refresh_sched;

  localparam int         D  = 2;
  localparam int         NE = 16;
  localparam int         W  = 10;
  localparam logic [8:0] P  = 9'h11B;
  localparam int         PB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         dp_re, dp_we, start, rnd_valid;
  logic [3:0]   dp_addr;
  logic [W-1:0] dp_wdata, dp_rdata;
  logic [D-1:0] rnd_data;
  logic         dp_rvalid, rnd_ready, busy, sweep_done;

  logic         start_b;
  logic         b_re = 1'b0, b_we = 1'b0, b_rv = 1'b1;
  logic [3:0]   b_addr = 4'd0;
  logic [W-1:0] b_wdata = '0, b_rdata;
  logic [D-1:0] b_rnd = '0;
  logic         b_rvalid, b_ready, busy_b, done_b;

  rambam_refresh_sched #(.D(D), .P(P), .NUM_ENT(NE), .PERIOD(0)) u_dut (
    .clk(clk), .rst(rst), .dp_re(dp_re), .dp_we(dp_we), .dp_addr(dp_addr),
    .dp_wdata(dp_wdata), .dp_rdata(dp_rdata), .dp_rvalid(dp_rvalid),
    .start(start), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
    .rnd_ready(rnd_ready), .busy(busy), .sweep_done(sweep_done)
  );

  rambam_refresh_sched #(.D(D), .P(P), .NUM_ENT(NE), .PERIOD(PB)) u_auto (
    .clk(clk), .rst(rst), .dp_re(b_re), .dp_we(b_we), .dp_addr(b_addr),
    .dp_wdata(b_wdata), .dp_rdata(b_rdata), .dp_rvalid(b_rvalid),
    .start(start_b), .rnd_valid(b_rv), .rnd_data(b_rnd),
    .rnd_ready(b_ready), .busy(busy_b), .sweep_done(done_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // GF(2) helpers: r * P without reduction, and reduction of a share mod P.
  function automatic logic [W-1:0] clmul(input logic [D-1:0] r);
    logic [W-1:0] acc;
    acc = '0;
    for (int i = 0; i < D; i++) if (r[i]) acc ^= ({1'b0, P} << i);
    return acc;
  endfunction

  function automatic logic [7:0] polymod(input logic [W-1:0] x);
    for (int b = W - 1; b >= 8; b--) if (x[b]) x ^= ({1'b0, P} << (b - 8));
    return x[7:0];
  endfunction

  // Reference model: contents, sweep progress (entry index and whether the
  // current entry already got its random word), read port, done pulse.
  logic [W-1:0] ment [NE];
  bit           m_active, m_after, m_done, m_rvalid;
  logic [3:0]   m_idx;
  logic [W-1:0] m_rdata;

  task automatic model_reset();
    for (int i = 0; i < NE; i++) ment[i] = '0;
    m_active = 0; m_after = 0; m_done = 0; m_rvalid = 0;
    m_idx = '0; m_rdata = '0;
  endtask

  task automatic idle_inputs();
    dp_re = 0; dp_we = 0; dp_addr = '0; dp_wdata = '0;
    start = 0; rnd_valid = 0; rnd_data = '0;
  endtask

  // One clock: check the combinational handshake, advance the model at the
  // edge, then check the registered outputs.
  task automatic tick();
    bit exp_ready, take;
    exp_ready = m_active && !m_after && !(dp_we && dp_addr == m_idx);
    #2;
    check("rnd_ready", rnd_ready, exp_ready);
    @(posedge clk);
    take = exp_ready && rnd_valid;
    if (rst) begin
      model_reset();
    end else begin
      m_done   = 0;
      m_rvalid = dp_re && !dp_we;
      if (m_rvalid) m_rdata = ment[dp_addr];
      if (take) ment[m_idx] ^= clmul(rnd_data);
      if (dp_we) ment[dp_addr] = dp_wdata;
      if (!m_active) begin
        if (start) begin m_active = 1; m_idx = '0; m_after = 0; end
      end else if (!m_after) begin
        m_after = take;
      end else begin
        m_after = 0;
        if (m_idx == 4'(NE - 1)) begin m_active = 0; m_done = 1; end
        else m_idx++;
      end
    end
    #1;
    check("busy", busy, m_active);
    check("sweep_done", sweep_done, m_done);
    check("dp_rvalid", dp_rvalid, m_rvalid);
    check("dp_rdata", dp_rdata, m_rdata);
  endtask

  task automatic read_entry(input logic [3:0] a, output logic [W-1:0] v);
    dp_re = 1; dp_addr = a;
    tick();
    dp_re = 0;
    v = dp_rdata;
  endtask

  task automatic read_all();
    logic [W-1:0] v;
    for (int i = 0; i < NE; i++) read_entry(4'(i), v);
  endtask

  task automatic launch();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic finish_sweep(input bit rand_rnd);
    int n = 0;
    while (m_active && n < 400) begin
      if (rand_rnd) rnd_data = D'($urandom);
      tick();
      n++;
    end
    check("sweep_finished", busy, 1'b0);
  endtask

  task automatic wait_fetch(input logic [3:0] idx);
    int n = 0;
    while (!(m_active && !m_after && m_idx == idx) && n < 100) begin
      tick();
      n++;
    end
    check("reached_fetch", n < 100, 1'b1);
  endtask

  initial begin
    logic [W-1:0] v;
    logic [D-1:0] r;
    int bc, dc;

    idle_inputs();
    start_b = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tick();
    rst = 0;

    // Auto sweep: busy from edge PB for 2*NE cycles; start while busy ignored.
    for (int n = 1; n <= 45; n++) begin
      start_b = (n == 20);
      tick();
      check("auto_busy", busy_b, (n >= PB) && (n < PB + 2 * NE));
      check("auto_done", done_b, n == PB + 2 * NE);
    end
    start_b = 0;

    // Zero-random sweep: 32 busy cycles, one done pulse, contents untouched.
    rnd_valid = 1; rnd_data = '0;
    launch();
    bc = busy; dc = 0;
    repeat (40) begin tick(); bc += busy; dc += sweep_done; end
    check("busy_cycles", bc, 2 * NE);
    check("done_pulses", dc, 1);
    read_all();

    // Entry 3 = 0x2A5, refresh with r=1 adds P; residue mod P is kept.
    dp_we = 1;
    for (int i = 0; i < NE; i++) begin
      dp_addr = 4'(i);
      dp_wdata = (i == 3) ? 10'h2A5 : W'($urandom);
      tick();
    end
    dp_we = 0;
    rnd_valid = 1; rnd_data = 2'b01;
    launch();
    finish_sweep(0);
    read_entry(4'd3, v);
    check("ent3_refreshed", v, 10'h2A5 ^ {1'b0, P});
    check("ent3_residue", polymod(v), polymod(10'h2A5));

    // RNG stall for 50 cycles mid-sweep.
    launch();
    wait_fetch(4'd4);
    rnd_valid = 0;
    repeat (50) tick();
    check("stall_busy", busy, 1'b1);
    rnd_valid = 1;
    finish_sweep(1);
    read_all();

    // Datapath write to entry 5 while it is being fetched.
    launch();
    wait_fetch(4'd5);
    r = D'($urandom | 1);
    rnd_data = r;
    dp_we = 1; dp_addr = 4'd5; dp_wdata = 10'h0FF;
    tick();
    dp_we = 0;
    tick();
    finish_sweep(1);
    read_entry(4'd5, v);
    check("ent5_conflict", v, 10'h0FF ^ clmul(r));

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      dp_re     = ($urandom_range(0, 2) == 0);
      dp_we     = ($urandom_range(0, 3) == 0);
      dp_addr   = 4'($urandom);
      dp_wdata  = W'($urandom);
      start     = ($urandom_range(0, 19) == 0);
      rnd_valid = ($urandom_range(0, 3) != 0);
      rnd_data  = D'($urandom);
      tick();
    end
    idle_inputs();
    rnd_valid = 1;
    finish_sweep(1);
    read_all();

    // Reset in the middle of a sweep, then a clean sweep from entry 0.
    launch();
    wait_fetch(4'd7);
    rst = 1;
    tick();
    rst = 0;
    check("rst_busy", busy, 1'b0);
    read_all();
    launch();
    check("restart_busy", busy, 1'b1);
    finish_sweep(1);
    read_all();
    check("auto_rdata", b_rdata, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
